// File: rtl/io_input_responder_if.sv
// io_input_responder_if: CPU IO read bus between MemOrIO (master) and the input responder (slave).
//   io_read : CPU IO read strobe
//   addr    : byte address (ALUResult)
//   rdata   : read data returned to the MemOrIO mux
`timescale 1ns/1ps
interface io_input_responder_if;
    logic        io_read;
    logic [31:0] addr;
    logic [31:0] rdata;
    modport master (output io_read, addr, input rdata);
    modport slave  (input io_read, addr, output rdata);
endinterface

// File: rtl/io_input_responder.sv
// io_input_responder: memory-mapped switch/button responder on the CPU IO read path.
//   clk                : CPU clock, all state on rising edge
//   rst_n              : asynchronous active-low reset
//   bus                : slave side of the IO read bus (io_read, addr in; rdata out)
//   sw_little, sw_big  : little/big switches, asynchronous
//   button0..button3   : raw bouncing push buttons, asynchronous
// Register window at IO_BASE: 0x00 little switches, 0x04 big switches,
// 0x08 debounced levels, 0x0C sticky press flags (clear on read), 0x10 button0 press count.
`timescale 1ns/1ps
module io_input_responder #(
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FC00,
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter int          CNT_W           = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    io_input_responder_if.slave     bus,
    input  logic [7:0]              sw_little,
    input  logic [7:0]              sw_big,
    input  logic                    button0,
    input  logic                    button1,
    input  logic                    button2,
    input  logic                    button3
);
    logic [19:0] pins, s1, s2;
    logic [3:0]  btn_sync, btn_level, rise, press_flag;
    logic [7:0]  press_count;
    logic [31:0] off;
    logic [2:0]  sel;
    logic        in_win, clr;

    assign pins     = {button3, button2, button1, button0, sw_big, sw_little};
    assign btn_sync = s2[19:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic             lvl;
        logic [CNT_W-1:0] cnt;
        logic             done;
        // accept the new level once it has differed for DEBOUNCE_CYCLES consecutive cycles
        assign done         = (btn_sync[i] != lvl) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        assign rise[i]      = done & btn_sync[i];
        assign btn_level[i] = lvl;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= (btn_sync[i] == lvl || done) ? '0 : cnt + 1'b1;
                if (done)
                    lvl <= btn_sync[i];
            end
        end
    end

    // word offset into the window; anything below IO_BASE wraps to a huge value and misses
    assign off    = bus.addr - IO_BASE;
    assign sel    = off[4:2];
    assign in_win = bus.io_read && (off[31:5] == 27'd0);
    assign clr    = in_win && (sel == 3'd3);

    always_comb begin
        bus.rdata = !in_win     ? 32'h0 :
                    sel == 3'd0 ? {24'b0, s2[7:0]} :
                    sel == 3'd1 ? {24'b0, s2[15:8]} :
                    sel == 3'd2 ? {28'b0, btn_level} :
                    sel == 3'd3 ? {28'b0, press_flag} :
                    sel == 3'd4 ? {24'b0, press_count} : 32'h0;
    end

    // a press landing on the clearing edge survives: set is OR-ed after the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_flag  <= '0;
            press_count <= '0;
        end else begin
            press_flag  <= (clr ? 4'b0 : press_flag) | rise;
            press_count <= press_count + {7'b0, rise[0]};
        end
    end
endmodule

// File: tb/tb_io_input_responder.sv
// tb_io_input_responder: scoreboard bench for io_input_responder with DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_io_input_responder;
    localparam logic [31:0] BASE = 32'hFFFF_FC00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw_little = 8'h0, sw_big = 8'h0;
    logic       b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
    int         checks = 0, errors = 0;
    logic [31:0] sb[$];
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    io_input_responder_if bus();

    io_input_responder #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sw_little(sw_little), .sw_big(sw_big),
        .button0(b0), .button1(b1), .button2(b2), .button3(b3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one bus cycle: expectation queued at drive time, popped when rdata is sampled mid-cycle
    task automatic access(input string tag, input logic rd, input logic [31:0] a, input logic [31:0] exp);
        sb.push_back(exp);
        bus.io_read = rd;
        bus.addr    = a;
        #4;
        check(tag, bus.rdata, sb.pop_front());
        @(posedge clk);
        #1;
        bus.io_read = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] o, input logic [31:0] exp);
        access(tag, 1'b1, BASE + {24'b0, o}, exp);
    endtask

    task automatic press0();
        b0 = 1'b1;
        cyc(7);
        b0 = 1'b0;
        cyc(7);
        exp_cnt++;
    endtask

    initial begin
        bus.io_read = 1'b0;
        bus.addr    = 32'h0;
        sw_little   = 8'hA5;
        b0          = 1'b1;
        cyc(2);
        rd("rst_sw", 8'h00, 32'h0);
        rd("rst_lvl", 8'h08, 32'h0);
        rd("rst_flag", 8'h0C, 32'h0);
        rd("rst_cnt", 8'h10, 32'h0);
        rst_n = 1'b1;
        cyc(2);
        rd("sw_sync", 8'h00, 32'h0000_00A5);
        cyc(5);
        rd("held_cnt", 8'h10, 32'h1);
        rd("held_flag", 8'h0C, 32'h1);
        rd("held_clr", 8'h0C, 32'h0);
        b0 = 1'b0;
        cyc(8);

        b2 = 1'b1;
        cyc(5);
        rd("clean_early", 8'h08, 32'h0);
        rd("clean_lvl", 8'h08, 32'h4);
        rd("clean_flag", 8'h0C, 32'h4);
        rd("clean_clr", 8'h0C, 32'h0);

        b1 = 1'b1; cyc(1);
        b1 = 1'b0; cyc(1);
        b1 = 1'b1; cyc(1);
        b1 = 1'b0; cyc(1);
        b1 = 1'b1;
        cyc(5);
        rd("bounce_early", 8'h08, 32'h4);
        rd("bounce_lvl", 8'h08, 32'h6);
        rd("bounce_flag", 8'h0C, 32'h2);
        cyc(10);
        rd("bounce_once", 8'h0C, 32'h0);

        b3 = 1'b1;
        cyc(8);
        b0 = 1'b1;
        cyc(5);
        rd("coll_old", 8'h0C, 32'h8);
        rd("coll_set", 8'h0C, 32'h1);
        rd("coll_cnt", 8'h10, 32'h2);
        rd("coll_lvl", 8'h08, 32'hF);

        b0 = 1'b0; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        rd("rst2_cnt", 8'h10, 32'h0);
        rd("rst2_lvl", 8'h08, 32'h0);
        rst_n = 1'b1;
        cyc(3);
        exp_cnt = 8'h0;
        repeat (256) press0();
        rd("wrap_256", 8'h10, {24'b0, exp_cnt});
        press0();
        rd("wrap_257", 8'h10, {24'b0, exp_cnt});

        sw_big = 8'h3C;
        cyc(3);
        access("no_read", 1'b0, BASE + 32'h4, 32'h0);
        rd("past_win", 8'h14, 32'h0);
        access("below_win", 1'b1, BASE - 32'h4, 32'h0);
        rd("big_sw", 8'h04, 32'h0000_003C);
        rd("byte_off", 8'h02, 32'h0000_00A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
